multi_event_counter: RTL

Parametrised multi-channel event counter for the instrumentation/debug path. Counts qualified single-bit events on NCH independent channels of WIDTH bits, with a run-time wrap/saturate mode, per-channel clear and a coherent snapshot of all channels into readable shadow registers. It supersedes the single-channel fixed-width saturating counter.

---
 rtl/multi_event_counter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/multi_event_counter.sv
// multi_event_counter: NCH-channel wrap/saturate event counter with snapshot.
// Define MULTI_EVENT_COUNTER_OVF_EN for sticky ovf flags and the irq output.
module multi_event_counter #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32,
  parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic [NCH-1:0]       din,
  input  logic [NCH-1:0]       clr,
  input  logic                 snap,
  input  logic [SELW-1:0]      rd_sel,
  output logic [NCH*WIDTH-1:0] cnt,
  output logic [NCH-1:0]       full,
  output logic                 snap_valid,
  output logic [WIDTH-1:0]     rd_data,
`ifdef MULTI_EVENT_COUNTER_OVF_EN
  output logic                 irq,
`endif
  output logic [NCH-1:0]       ovf
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] cnt_q    [NCH];
  logic [WIDTH-1:0] cnt_d    [NCH];
  logic [WIDTH-1:0] shadow_q [NCH];
  logic [WIDTH-1:0] shadow_d [NCH];
  logic [NCH-1:0]   full_q;
  logic [NCH-1:0]   full_d;
  logic             snap_valid_q;
  logic             snap_valid_d;

  // Per-channel next count: clear beats increment beats hold.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr[i]) begin
        cnt_d[i] = '0;
      end else if (start && din[i]) begin
        if (cnt_q[i] != MAX) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end else if (!mode) begin
          cnt_d[i] = '0;
        end
      end
      full_d[i] = (cnt_d[i] == MAX);
    end
  end

  // Shadow capture uses the pre-update count so same-edge activity is ignored.
  always_comb begin
    snap_valid_d = snap;
    for (int i = 0; i < NCH; i++) begin
      shadow_d[i] = snap ? cnt_q[i] : shadow_q[i];
    end
  end

  // Counter, full, shadow and pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      full_q       <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      full_q       <= full_d;
      snap_valid_q <= snap_valid_d;
    end
  end

`ifdef MULTI_EVENT_COUNTER_OVF_EN
  logic [NCH-1:0] ovf_q;
  logic [NCH-1:0] ovf_d;
  logic           irq_q;
  logic           irq_d;

  // Sticky wrap flags; a clear on the same edge as a wrap leaves the flag low.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ovf_d[i] = ovf_q[i];
      if (clr[i]) begin
        ovf_d[i] = 1'b0;
      end else if (start && din[i] && !mode && cnt_q[i] == MAX) begin
        ovf_d[i] = 1'b1;
      end
    end
    irq_d = |ovf_d;
  end

  // Flag and interrupt registers, updated on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      irq_q <= irq_d;
    end
  end

  assign ovf = ovf_q;
  assign irq = irq_q;
`else
  assign ovf = '0;
`endif

  // Flatten live counts and mux the selected shadow; out-of-range reads 0.
  always_comb begin
    cnt     = '0;
    rd_data = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt[i*WIDTH +: WIDTH] = cnt_q[i];
      if (rd_sel == SELW'(i)) begin
        rd_data = shadow_q[i];
      end
    end
  end

  assign full       = full_q;
  assign snap_valid = snap_valid_q;

endmodule
